// File: rtl/spi_deser_pkg.sv
// Shared types and constants for the SPI burst deserializer.
//   state_e       : FSM state encoding (IDLE, SKIP, SHIFT, DRAIN)
//   DEF_*         : default parameter values
//   byte_reverse  : reverses the byte order of a WORD_W-bit word
package spi_deser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SKIP  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam int unsigned DEF_WORD_W     = 16;
  localparam int unsigned DEF_NUM_WORDS  = 6;
  localparam int unsigned DEF_SKIP_BITS  = 8;
  localparam int unsigned DEF_SWAP_BYTES = 1;
  localparam int unsigned MAX_WORD_W     = 32;

  // Reverse byte order of the low n_bytes bytes of word (zero-extended).
  // All four bytes are reversed, which parks the word in the top bytes;
  // the right shift then brings it back down to bit 0.
  function automatic logic [MAX_WORD_W-1:0] byte_reverse(
    input logic [MAX_WORD_W-1:0] word,
    input int unsigned           n_bytes
  );
    logic [MAX_WORD_W-1:0] full;
    full = {word[7:0], word[15:8], word[23:16], word[31:24]};
    return full >> (MAX_WORD_W - 8 * n_bytes);
  endfunction

endpackage

// File: rtl/spi_burst_deserializer.sv
// Deserializes a burst of sensor words from an SPI slave stream, clocked
// directly by the SPI clock. Leading command bits are discarded, then
// NUM_WORDS words of WORD_W bits are captured, optionally byte-swapped.
// Ports:
//   rp2350_sck   in   SPI clock (rising edge is the only active edge)
//   rst_n        in   asynchronous active-low reset
//   rp2350_cs    in   chip select, active low
//   rp2350_miso  in   serial data, MSB first within each byte
//   data_out     out  last completed word, held until the next one
//   word_idx     out  burst index of the word in data_out
//   data_valid   out  one-cycle pulse when a word completes
//   frame_done   out  one-cycle pulse with data_valid for the last word
//   short_frame  out  one-cycle pulse when CS rises before the burst ends
module spi_burst_deserializer
  import spi_deser_pkg::*;
#(
  parameter  int unsigned WORD_W     = DEF_WORD_W,
  parameter  int unsigned NUM_WORDS  = DEF_NUM_WORDS,
  parameter  int unsigned SKIP_BITS  = DEF_SKIP_BITS,
  parameter  int unsigned SWAP_BYTES = DEF_SWAP_BYTES,
  localparam int unsigned IDX_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic              rp2350_sck,
  input  logic              rst_n,
  input  logic              rp2350_cs,
  input  logic              rp2350_miso,
  output logic [WORD_W-1:0] data_out,
  output logic [IDX_W-1:0]  word_idx,
  output logic              data_valid,
  output logic              frame_done,
  output logic              short_frame
);

  localparam int unsigned BIT_MAX = (WORD_W > SKIP_BITS) ? WORD_W : SKIP_BITS;
  localparam int unsigned CNT_W   = $clog2(BIT_MAX + 1);

  // Parameter legality, checked at elaboration.
  if ((WORD_W % 8) != 0 || WORD_W < 8 || WORD_W > MAX_WORD_W) begin : g_bad_word_w
    $error("WORD_W must be a multiple of 8 in 8..32");
  end
  if (NUM_WORDS < 1 || NUM_WORDS > 16) begin : g_bad_num_words
    $error("NUM_WORDS must be in 1..16");
  end
  if (SKIP_BITS > 16) begin : g_bad_skip_bits
    $error("SKIP_BITS must be in 0..16");
  end
  if (SWAP_BYTES > 1) begin : g_bad_swap_bytes
    $error("SWAP_BYTES must be 0 or 1");
  end

  state_e             state_q,    state_d;
  logic [CNT_W-1:0]   bit_cnt_q,  bit_cnt_d;
  logic [IDX_W-1:0]   word_cnt_q, word_cnt_d;
  // Holds WORD_W-1 bits: the final bit of a word goes straight to data_out.
  logic [WORD_W-2:0]  shift_q,    shift_d;
  logic [WORD_W-1:0]  data_q,     data_d;
  logic [IDX_W-1:0]   idx_q,      idx_d;
  logic               valid_q,    valid_d;
  logic               done_q,     done_d;
  logic               short_q,    short_d;

  logic [WORD_W-1:0]  shift_nxt;
  logic [WORD_W-1:0]  word_ordered;

  // Incoming word including the bit sampled on this edge, byte-ordered.
  always_comb begin
    shift_nxt = {shift_q, rp2350_miso};
    if (SWAP_BYTES != 0) begin
      word_ordered = WORD_W'(byte_reverse(MAX_WORD_W'(shift_nxt), WORD_W / 8));
    end else begin
      word_ordered = shift_nxt;
    end
  end

  // State and output registers.
  always_ff @(posedge rp2350_sck or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      short_q    <= short_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    idx_d      = idx_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    short_d    = 1'b0;

    if (rp2350_cs) begin
      // CS high aborts from any state; only SKIP/SHIFT count as short frames.
      state_d    = ST_IDLE;
      bit_cnt_d  = '0;
      word_cnt_d = '0;
      short_d    = (state_q == ST_SKIP) || (state_q == ST_SHIFT);
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // The bit sampled with the first CS-low edge is frame bit 1.
          if (SKIP_BITS == 0) begin
            shift_d   = shift_nxt[WORD_W-2:0];
            bit_cnt_d = CNT_W'(1);
            state_d   = ST_SHIFT;
          end else if (SKIP_BITS == 1) begin
            bit_cnt_d = '0;
            state_d   = ST_SHIFT;
          end else begin
            bit_cnt_d = CNT_W'(1);
            state_d   = ST_SKIP;
          end
        end

        ST_SKIP: begin
          if (bit_cnt_q == CNT_W'(SKIP_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = ST_SHIFT;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end

        ST_SHIFT: begin
          shift_d = shift_nxt[WORD_W-2:0];
          if (bit_cnt_q == CNT_W'(WORD_W - 1)) begin
            bit_cnt_d = '0;
            data_d    = word_ordered;
            idx_d     = word_cnt_q;
            valid_d   = 1'b1;
            if (word_cnt_q == IDX_W'(NUM_WORDS - 1)) begin
              done_d     = 1'b1;
              word_cnt_d = '0;
              state_d    = ST_DRAIN;
            end else begin
              word_cnt_d = word_cnt_q + 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end

        ST_DRAIN: begin
          // Trailing bits after the burst are ignored until CS rises.
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign data_out    = data_q;
  assign word_idx    = idx_q;
  assign data_valid  = valid_q;
  assign frame_done  = done_q;
  assign short_frame = short_q;

endmodule

// File: tb/tb_spi_burst_deserializer.sv
// Scoreboard bench for spi_burst_deserializer: a default instance and a
// SWAP_BYTES=0 / SKIP_BITS=0 / NUM_WORDS=1 instance on a shared clock.
module tb_spi_burst_deserializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cs0, miso0, cs1, miso1;
  logic [15:0] data0, data1;
  logic [2:0]  idx0;
  logic [0:0]  idx1;
  logic        v0, fd0, sf0, v1, fd1, sf1;

  spi_burst_deserializer u_dut0 (
    .rp2350_sck (clk),
    .rst_n      (rst_n),
    .rp2350_cs  (cs0),
    .rp2350_miso(miso0),
    .data_out   (data0),
    .word_idx   (idx0),
    .data_valid (v0),
    .frame_done (fd0),
    .short_frame(sf0)
  );

  spi_burst_deserializer #(
    .WORD_W    (16),
    .NUM_WORDS (1),
    .SKIP_BITS (0),
    .SWAP_BYTES(0)
  ) u_dut1 (
    .rp2350_sck (clk),
    .rst_n      (rst_n),
    .rp2350_cs  (cs1),
    .rp2350_miso(miso1),
    .data_out   (data1),
    .word_idx   (idx1),
    .data_valid (v1),
    .frame_done (fd1),
    .short_frame(sf1)
  );

  typedef struct {
    logic [15:0] data;
    int unsigned idx;
    logic        fd;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  int checks   = 0;
  int failures = 0;
  int vcnt0 = 0, vcnt1 = 0, sfcnt0 = 0, sfcnt1 = 0;

  // Scoreboard monitors: every data_valid pops one expected word.
  always @(negedge clk) begin
    if (v0) begin
      vcnt0++;
      checks++;
      if (q0.size() == 0) begin
        failures++;
        $display("FAIL dut0_unexpected_valid got data=%h idx=%0d fd=%b, required no pulse", data0, idx0, fd0);
      end else begin
        e0 = q0.pop_front();
        if (data0 !== e0.data || idx0 !== 3'(e0.idx) || fd0 !== e0.fd) begin
          failures++;
          $display("FAIL dut0_word got data=%h idx=%0d fd=%b, required data=%h idx=%0d fd=%b",
                   data0, idx0, fd0, e0.data, e0.idx, e0.fd);
        end
      end
    end else if (fd0) begin
      checks++;
      failures++;
      $display("FAIL dut0_frame_done_alone got frame_done=1, required 0 without data_valid");
    end
    if (sf0) sfcnt0++;
  end

  always @(negedge clk) begin
    if (v1) begin
      vcnt1++;
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL dut1_unexpected_valid got data=%h idx=%0d fd=%b, required no pulse", data1, idx1, fd1);
      end else begin
        e1 = q1.pop_front();
        if (data1 !== e1.data || idx1 !== 1'(e1.idx) || fd1 !== e1.fd) begin
          failures++;
          $display("FAIL dut1_word got data=%h idx=%0d fd=%b, required data=%h idx=%0d fd=%b",
                   data1, idx1, fd1, e1.data, e1.idx, e1.fd);
        end
      end
    end else if (fd1) begin
      checks++;
      failures++;
      $display("FAIL dut1_frame_done_alone got frame_done=1, required 0 without data_valid");
    end
    if (sf1) sfcnt1++;
  end

  // ---- stimulus primitives (inputs change on the falling edge) ----
  task automatic tick0(input logic c, input logic m);
    @(negedge clk);
    cs0   = c;
    miso0 = m;
  endtask

  task automatic tick1(input logic c, input logic m);
    @(negedge clk);
    cs1   = c;
    miso1 = m;
  endtask

  task automatic byte0(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) tick0(1'b0, b[i]);
  endtask

  task automatic byte1(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) tick1(1'b0, b[i]);
  endtask

  task automatic idle0(input int n);
    repeat (n) tick0(1'b1, 1'b0);
  endtask

  task automatic idle1(input int n);
    repeat (n) tick1(1'b1, 1'b0);
  endtask

  // Sensor sends low byte first; with swapping the word comes out intact.
  task automatic word0(input logic [15:0] w, input int unsigned idx, input logic fd);
    exp_t e;
    e.data = w;
    e.idx  = idx;
    e.fd   = fd;
    q0.push_back(e);
    byte0(w[7:0]);
    byte0(w[15:8]);
  endtask

  task automatic burst0(input logic [15:0] base);
    byte0(8'hA5);
    for (int k = 0; k < 6; k++) word0(base + 16'(k), k, (k == 5));
  endtask

  // ---- tests ----
  task automatic test_reset();
    rst_n = 1'b1; cs0 = 1'b1; miso0 = 1'b0; cs1 = 1'b1; miso1 = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({data0, idx0, v0, fd0, sf0} !== 22'd0) begin
      failures++;
      $display("FAIL reset_dut0 got data=%h idx=%0d v=%b fd=%b sf=%b, required all 0", data0, idx0, v0, fd0, sf0);
    end
    checks++;
    if ({data1, idx1, v1, fd1, sf1} !== 20'd0) begin
      failures++;
      $display("FAIL reset_dut1 got data=%h idx=%0d v=%b fd=%b sf=%b, required all 0", data1, idx1, v1, fd1, sf1);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle0(2);
  endtask

  task automatic test_single_word();
    int vb, sb;
    vb = vcnt0; sb = sfcnt0;
    byte0(8'hA5);
    word0(16'h1234, 0, 1'b0);
    idle0(4);
    checks++;
    if (vcnt0 - vb !== 1) begin
      failures++;
      $display("FAIL single_valid_count got %0d, required 1", vcnt0 - vb);
    end
    checks++;
    if (data0 !== 16'h1234 || idx0 !== 3'd0) begin
      failures++;
      $display("FAIL single_hold got data=%h idx=%0d, required 1234 idx=0", data0, idx0);
    end
    checks++;
    if (sfcnt0 - sb !== 1) begin
      failures++;
      $display("FAIL single_short got %0d, required 1", sfcnt0 - sb);
    end
  endtask

  task automatic test_full_burst();
    int vb, sb;
    vb = vcnt0; sb = sfcnt0;
    burst0(16'h0001);
    idle0(3);
    checks++;
    if (vcnt0 - vb !== 6 || q0.size() !== 0) begin
      failures++;
      $display("FAIL burst_count got %0d pending=%0d, required 6 pending=0", vcnt0 - vb, q0.size());
    end
    checks++;
    if (sfcnt0 - sb !== 0) begin
      failures++;
      $display("FAIL burst_short got %0d, required 0", sfcnt0 - sb);
    end
    checks++;
    if (data0 !== 16'h0006 || idx0 !== 3'd5) begin
      failures++;
      $display("FAIL burst_hold got data=%h idx=%0d, required 0006 idx=5", data0, idx0);
    end
  endtask

  task automatic test_short_frame();
    int vb, sb;
    logic [15:0] w;
    vb = vcnt0; sb = sfcnt0;
    w = 16'h0003;
    byte0(8'hA5);
    word0(16'h0001, 0, 1'b0);
    word0(16'h0002, 1, 1'b0);
    byte0(w[7:0]);
    tick0(1'b0, w[15]);
    tick0(1'b0, w[14]);
    idle0(4);
    checks++;
    if (vcnt0 - vb !== 2 || q0.size() !== 0) begin
      failures++;
      $display("FAIL short_valid_count got %0d pending=%0d, required 2 pending=0", vcnt0 - vb, q0.size());
    end
    checks++;
    if (sfcnt0 - sb !== 1) begin
      failures++;
      $display("FAIL short_pulse got %0d, required 1", sfcnt0 - sb);
    end
    checks++;
    if (data0 !== 16'h0002 || idx0 !== 3'd1) begin
      failures++;
      $display("FAIL short_hold got data=%h idx=%0d, required 0002 idx=1", data0, idx0);
    end
    // Abort during the command bits is also a short frame.
    sb = sfcnt0; vb = vcnt0;
    repeat (4) tick0(1'b0, 1'b1);
    idle0(3);
    checks++;
    if (sfcnt0 - sb !== 1 || vcnt0 - vb !== 0) begin
      failures++;
      $display("FAIL skip_abort got short=%0d valid=%0d, required short=1 valid=0", sfcnt0 - sb, vcnt0 - vb);
    end
  endtask

  task automatic test_back_to_back();
    int vb, sb;
    logic [15:0] base;
    vb = vcnt0; sb = sfcnt0;
    base = 16'($urandom_range(16'h1000, 16'hF000));
    burst0(16'h0100);
    repeat (24) tick0(1'b0, 1'($urandom));
    tick0(1'b1, 1'b0);
    burst0(base);
    idle0(3);
    checks++;
    if (vcnt0 - vb !== 12 || q0.size() !== 0) begin
      failures++;
      $display("FAIL b2b_count got %0d pending=%0d, required 12 pending=0", vcnt0 - vb, q0.size());
    end
    checks++;
    if (sfcnt0 - sb !== 0) begin
      failures++;
      $display("FAIL b2b_short got %0d, required 0", sfcnt0 - sb);
    end
  endtask

  task automatic test_mid_reset();
    int vb, sb;
    sb = sfcnt0;
    byte0(8'hA5);
    word0(16'h0001, 0, 1'b0);
    word0(16'h0002, 1, 1'b0);
    word0(16'h0003, 2, 1'b0);
    repeat (5) tick0(1'b0, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({data0, idx0, v0, fd0, sf0} !== 22'd0) begin
      failures++;
      $display("FAIL midreset_outputs got data=%h idx=%0d v=%b fd=%b sf=%b, required all 0", data0, idx0, v0, fd0, sf0);
    end
    @(negedge clk);
    cs0 = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle0(2);
    vb = vcnt0;
    burst0(16'h00A0);
    idle0(3);
    checks++;
    if (vcnt0 - vb !== 6 || q0.size() !== 0) begin
      failures++;
      $display("FAIL midreset_burst got %0d pending=%0d, required 6 pending=0", vcnt0 - vb, q0.size());
    end
    checks++;
    if (sfcnt0 - sb !== 0) begin
      failures++;
      $display("FAIL midreset_short got %0d, required 0", sfcnt0 - sb);
    end
  endtask

  task automatic test_no_swap();
    int vb, sb;
    exp_t e;
    vb = vcnt1; sb = sfcnt1;
    e.data = 16'h3412; e.idx = 0; e.fd = 1'b1;
    q1.push_back(e);
    byte1(8'h34);
    byte1(8'h12);
    repeat (5) tick1(1'b0, 1'b1);
    idle1(3);
    checks++;
    if (vcnt1 - vb !== 1 || q1.size() !== 0) begin
      failures++;
      $display("FAIL noswap_count got %0d pending=%0d, required 1 pending=0", vcnt1 - vb, q1.size());
    end
    checks++;
    if (sfcnt1 - sb !== 0 || data1 !== 16'h3412) begin
      failures++;
      $display("FAIL noswap_hold got short=%0d data=%h, required short=0 data=3412", sfcnt1 - sb, data1);
    end
    sb = sfcnt1; vb = vcnt1;
    repeat (9) tick1(1'b0, 1'b0);
    idle1(3);
    checks++;
    if (sfcnt1 - sb !== 1 || vcnt1 - vb !== 0 || data1 !== 16'h3412) begin
      failures++;
      $display("FAIL noswap_abort got short=%0d valid=%0d data=%h, required short=1 valid=0 data=3412",
               sfcnt1 - sb, vcnt1 - vb, data1);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_full_burst();
    test_short_frame();
    test_back_to_back();
    test_mid_reset();
    test_no_swap();
    idle0(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_burst_deserializer.md
SPI_BURST_DESERIALIZER -- requirements
Module: spi_burst_deserializer

Interface
REQ-001 Parameter WORD_W, default 16, bits per sensor word; SHALL be a multiple of 8, range 8..32.
REQ-002 Parameter NUM_WORDS, default 6, words per burst (gyro XYZ plus accel XYZ); range 1..16.
REQ-003 Parameter SKIP_BITS, default 8, leading command/address bits discarded after CS falls; range 0..16.
REQ-004 Parameter SWAP_BYTES, default 1; 1 = sensor sends low byte first and bytes are reversed on output; 0 = output as received.
REQ-005 rp2350_sck  input  1  SPI clock; the only clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 rp2350_cs  input  1  chip select, active-low, sampled on rp2350_sck rising edge.
REQ-008 rp2350_miso  input  1  serial data, MSB-first within each byte, sampled on rp2350_sck rising edge.
REQ-009 data_out  output  WORD_W  last completed word, byte-ordered per SWAP_BYTES, held until the next word completes.
REQ-010 word_idx  output  max(1,$clog2(NUM_WORDS))  index within the burst of the word in data_out.
REQ-011 data_valid  output  1  one-cycle pulse; data_out and word_idx are valid on this cycle.
REQ-012 frame_done  output  1  one-cycle pulse, coincident with data_valid, for word NUM_WORDS-1.
REQ-013 short_frame  output  1  one-cycle pulse; CS rose before NUM_WORDS complete words were received.

Function
REQ-014 FSM states: IDLE, SKIP, SHIFT, DRAIN; all outputs SHALL be registered.
REQ-015 IDLE: when cs=0 is sampled, the bit sampled on that edge SHALL count as the first bit of the frame; go to SKIP, or to SHIFT if SKIP_BITS=0.
REQ-016 SKIP: discard exactly SKIP_BITS bits total, including the IDLE entry bit; go to SHIFT after the last one.
REQ-017 SHIFT: shift miso into LSB; on the edge sampling bit WORD_W of a word, data_out SHALL include that bit; data_valid pulses on the following cycle; no bit is lost.
REQ-018 With SWAP_BYTES=1, the first-received byte SHALL map to data_out[7:0] and the last-received byte to the top byte; the order of intermediate bytes is reversed accordingly.
REQ-019 word_idx SHALL increment per completed word from 0; after word NUM_WORDS-1, assert frame_done and go to DRAIN.
REQ-020 DRAIN: ignore further bits while cs=0; no data_valid pulses.
REQ-021 cs=1 sampled in any state SHALL return the FSM to IDLE and clear the bit and word counters; data_out and word_idx SHALL hold their values.
REQ-022 short_frame SHALL pulse when cs=1 is sampled in SKIP, or in SHIFT before the final word completes, including partial-word aborts; a partial word SHALL NOT produce data_valid.
REQ-023 short_frame SHALL NOT pulse for cs=1 in IDLE or DRAIN.
REQ-024 Back-to-back frames with a single cs=1 sample between them SHALL both be captured completely.
REQ-025 Counters SHALL be sized for their maximum value with no wrap: bit counter up to max(WORD_W, SKIP_BITS); word counter up to NUM_WORDS-1.

Reset
REQ-026 rst_n=0 SHALL, asynchronously, force state=IDLE, counters=0, shift register=0, data_out=0, word_idx=0, and data_valid=frame_done=short_frame=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame without any pulse; after release, the block SHALL wait in IDLE for the next cs=0 sample.

Structure
REQ-028 Package spi_deser_pkg SHALL hold the FSM state enum, the default parameter constants, and a byte-reverse function parametrised by WORD_W.
REQ-029 No sub-module is required; the block SHALL be a single module that imports spi_deser_pkg.
REQ-030 Legal parameter values SHALL be enforced by elaboration-time assertions.

Verification
REQ-031 Defaults; skip byte 0xA5, then bytes 0x34 then 0x12 -> data_out=0x1234, word_idx=0, data_valid high for exactly one cycle.
REQ-032 Defaults; full 6-word burst 0x0001..0x0006 -> six data_valid pulses, idx 0..5; frame_done with idx 5 and data 0x0006; no short_frame.
REQ-033 Defaults; cs rises after 10 bits of word 2 -> two data_valid pulses only, one short_frame pulse, data_out stays 0x0002.
REQ-034 Defaults; 24 extra bits after word 5, then cs=1 -> no extra data_valid, no short_frame; next frame captures word 0 correctly.
REQ-035 SWAP_BYTES=0, SKIP_BITS=0, NUM_WORDS=1; bytes 0x34, 0x12 -> data_out=0x3412, with frame_done and data_valid together.
REQ-036 Defaults; rst_n pulsed low mid-word 3 -> all outputs 0 immediately; next full burst correct from idx 0.
